// File: rtl/selector_nway_rr_pkg.sv
// selector_nway_rr shared definitions.
// Mode encodings and default geometry.
package selector_nway_rr_pkg;

    localparam logic MODE_FIXED   = 1'b0;
    localparam logic MODE_RR      = 1'b1;

    localparam int   DEF_WIDTH    = 4;
    localparam int   DEF_CHANNELS = 8;

endpackage

// File: rtl/selector_nway_rr_arb.sv
// rr_arbiter: rotate-priority request search.
// Picks the first request after ptr, wrapping mod N.
module rr_arbiter
    import selector_nway_rr_pkg::*;
#(
    parameter int N  = DEF_CHANNELS,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [PW-1:0] cand [N];

    for (genvar k = 0; k < N; k++) begin : g_cand
        assign cand[k] = PW'((int'(ptr) + k + 1) % N);
    end

    // first requesting candidate in rotated order wins
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!grant_valid && req[cand[k]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/selector_nway_rr.sv
// selector_nway_rr: N-channel registered selector.
// Fixed-select or round-robin, valid/ready both sides.
module selector_nway_rr
    import selector_nway_rr_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_valid;
    logic             fix_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_data;
    logic             load;

    rr_arbiter #(
        .N  (CHANNELS),
        .PW (SEL_W)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr),
        .grant_idx   (rr_idx),
        .grant_valid (rr_valid)
    );

    assign load = !out_valid || out_ready;

    // fixed grant: out-of-range sel matches no channel
    always_comb begin
        fix_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i)) begin
                fix_valid = in_valid[i];
            end
        end
    end

    // choose between fixed and round-robin grant
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        unique case (1'b1)
            (mode == MODE_RR): begin
                grant_idx   = rr_idx;
                grant_valid = rr_valid;
            end
            (mode == MODE_FIXED): begin
                grant_idx   = sel;
                grant_valid = fix_valid;
            end
            default: ;
        endcase
    end

    // data mux for the granted channel
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // one-hot accept, suppressed in reset and backpressure
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = rst_n && load && grant_valid
                          && (grant_idx == SEL_W'(i));
        end
    end

    // output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= SEL_W'(CHANNELS - 1);
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_chan  <= grant_idx;
                ptr       <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_selector_nway_rr.sv
// tb_selector_nway_rr: directed bench with spec model.
// Two instances: 8 channels and 5 channels.
module tb_selector_nway_rr;

    logic        clk;
    int          n_tests;
    int          n_fail;

    logic        rst_a;
    logic [31:0] a_id;
    logic [7:0]  a_iv;
    logic [7:0]  a_ird;
    logic        a_mode;
    logic [2:0]  a_sel;
    logic [3:0]  a_od;
    logic [2:0]  a_oc;
    logic        a_ov;
    logic        a_or;

    logic        rst_b;
    logic [19:0] b_id;
    logic [4:0]  b_iv;
    logic [4:0]  b_ird;
    logic        b_mode;
    logic [2:0]  b_sel;
    logic [3:0]  b_od;
    logic [2:0]  b_oc;
    logic        b_ov;
    logic        b_or;

    int          m_ptr [2];
    logic        m_v   [2];
    logic [3:0]  m_d   [2];
    int          m_c   [2];
    bit          armed [2];

    selector_nway_rr #(
        .WIDTH    (4),
        .CHANNELS (8)
    ) dut_a (
        .clk       (clk),
        .rst_n     (rst_a),
        .in_data   (a_id),
        .in_valid  (a_iv),
        .in_ready  (a_ird),
        .mode      (a_mode),
        .sel       (a_sel),
        .out_data  (a_od),
        .out_chan  (a_oc),
        .out_valid (a_ov),
        .out_ready (a_or)
    );

    selector_nway_rr #(
        .WIDTH    (4),
        .CHANNELS (5)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_b),
        .in_data   (b_id),
        .in_valid  (b_iv),
        .in_ready  (b_ird),
        .mode      (b_mode),
        .sel       (b_sel),
        .out_data  (b_od),
        .out_chan  (b_oc),
        .out_valid (b_ov),
        .out_ready (b_or)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h",
                     nm, act, exp);
        end
    endtask

    // Spec-level model: check current cycle, then
    // advance to the state after the coming edge.
    task automatic model_step(
        input int          u,
        input int          n,
        input logic        rst,
        input logic [7:0]  iv,
        input logic [31:0] id,
        input logic        md,
        input logic [2:0]  sl,
        input logic        ordy,
        input logic [7:0]  ird,
        input logic [3:0]  od,
        input logic [2:0]  oc,
        input logic        ov
    );
        int         g;
        bit         gv;
        bit         ld;
        logic [7:0] er;
        string      p;
        g  = 0;
        gv = 0;
        p  = (u == 0) ? "a" : "b";
        if (md == 1'b0) begin
            if (int'(sl) < n && iv[sl]) begin
                gv = 1;
                g  = int'(sl);
            end
        end else begin
            for (int k = 1; k <= n; k++) begin
                int c;
                c = (m_ptr[u] + k) % n;
                if (!gv && iv[c]) begin
                    gv = 1;
                    g  = c;
                end
            end
        end
        ld = !m_v[u] || ordy;
        er = (rst && ld && gv) ? 8'(1 << g) : 8'h0;
        if (armed[u]) begin
            cmp({p, ".m.in_ready"}, ird, er);
            cmp({p, ".m.out_valid"}, ov, m_v[u]);
            cmp({p, ".m.out_data"}, od, m_d[u]);
            cmp({p, ".m.out_chan"}, oc, m_c[u]);
        end
        if (!rst) begin
            m_v[u]   = 0;
            m_d[u]   = 0;
            m_c[u]   = 0;
            m_ptr[u] = n - 1;
            armed[u] = 1;
        end else if (ld) begin
            if (gv) begin
                m_v[u]   = 1;
                m_d[u]   = id[g*4 +: 4];
                m_c[u]   = g;
                m_ptr[u] = g;
            end else begin
                m_v[u] = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step(0, 8, rst_a, a_iv, a_id,
                       a_mode, a_sel, a_or, a_ird,
                       a_od, a_oc, a_ov);
            model_step(1, 5, rst_b, {3'b0, b_iv},
                       {12'b0, b_id}, b_mode, b_sel,
                       b_or, {3'b0, b_ird},
                       b_od, b_oc, b_ov);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int u = 0; u < 2; u++) begin
            armed[u] = 0;
            m_v[u]   = 0;
            m_d[u]   = 0;
            m_c[u]   = 0;
            m_ptr[u] = 0;
        end
        rst_a  = 0;
        a_id   = 32'h7654_3210;
        a_iv   = 8'hFF;
        a_mode = 1'b1;
        a_sel  = 3'd0;
        a_or   = 1'b1;
        rst_b  = 0;
        b_id   = 20'h4_3210;
        b_iv   = 5'h1F;
        b_mode = 1'b1;
        b_sel  = 3'd0;
        b_or   = 1'b1;

        cyc();
        cyc();
        cmp("rst.out_valid", a_ov, 0);
        cmp("rst.out_data", a_od, 0);
        cmp("rst.out_chan", a_oc, 0);
        cmp("rst.in_ready", a_ird, 0);
        cmp("rst.b.in_ready", b_ird, 0);
        rst_a = 1;
        rst_b = 1;
        b_iv  = 5'h00;
        #1;
        cmp("rst.first_ready", a_ird, 8'h01);

        cyc();
        cmp("rr.first_chan", a_oc, 0);
        cmp("rr.first_valid", a_ov, 1);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            cmp($sformatf("rr.sweep%0d.chan", i),
                a_oc, i % 8);
            cmp($sformatf("rr.sweep%0d.data", i),
                a_od, i % 8);
        end

        a_iv = 8'h44;
        cyc();
        cmp("rr.pair0", a_oc, 2);
        cyc();
        cmp("rr.pair1", a_oc, 6);
        cyc();
        cmp("rr.pair2", a_oc, 2);
        cyc();
        cmp("rr.pair3", a_oc, 6);

        a_mode = 1'b0;
        a_sel  = 3'd5;
        a_iv   = 8'hFF;
        a_id   = 32'h76A4_3210;
        #1;
        cmp("fix.in_ready", a_ird, 8'b0010_0000);
        cyc();
        cmp("fix.out_data", a_od, 4'hA);
        cmp("fix.out_chan", a_oc, 5);
        a_iv = 8'hDF;
        #1;
        cmp("fix.noval.ready", a_ird, 0);
        cyc();
        cmp("fix.drain.valid", a_ov, 0);
        cmp("fix.drain.data", a_od, 4'hA);
        cmp("fix.drain.chan", a_oc, 5);

        a_mode = 1'b1;
        a_iv   = 8'hFF;
        a_id   = 32'h7654_3210;
        cyc();
        cmp("bp.load.chan", a_oc, 6);
        a_or = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            cmp($sformatf("bp%0d.chan", i), a_oc, 6);
            cmp($sformatf("bp%0d.data", i), a_od, 6);
            cmp($sformatf("bp%0d.valid", i), a_ov, 1);
            cmp($sformatf("bp%0d.ready", i), a_ird, 0);
        end
        a_or = 1'b1;
        #1;
        cmp("bp.release.ready", a_ird, 8'h80);
        cyc();
        cmp("bp.next.chan", a_oc, 7);
        cmp("bp.next.data", a_od, 7);

        a_or   = 1'b0;
        a_mode = 1'b0;
        a_sel  = 3'd1;
        cyc();
        cmp("msw.held.chan", a_oc, 7);
        cmp("msw.held.data", a_od, 7);
        a_or = 1'b1;
        #1;
        cmp("msw.ready", a_ird, 8'h02);
        cyc();
        cmp("msw.fixed.chan", a_oc, 1);
        a_iv = 8'h00;
        cyc();

        b_iv = 5'h1F;
        cyc();
        cmp("b.first.chan", b_oc, 0);
        b_mode = 1'b0;
        b_sel  = 3'd6;
        #1;
        cmp("b.sel6.ready", b_ird, 0);
        cyc();
        cmp("b.sel6.valid", b_ov, 0);
        b_mode = 1'b1;
        b_iv   = 5'b10000;
        cyc();
        cmp("b.ch4.chan", b_oc, 4);
        b_iv = 5'b10001;
        #1;
        cmp("b.wrap.ready", b_ird, 5'b00001);
        cyc();
        cmp("b.wrap.chan", b_oc, 0);
        b_iv = 5'h1F;
        cyc();
        cmp("b.stream.chan", b_oc, 1);
        rst_b = 0;
        #1;
        cmp("b.rst.ready", b_ird, 0);
        cyc();
        cmp("b.rst.valid", b_ov, 0);
        cmp("b.rst.chan", b_oc, 0);
        rst_b = 1;
        #1;
        cmp("b.ptr4.ready", b_ird, 5'b00001);
        cyc();
        cmp("b.ptr4.chan", b_oc, 0);
        cmp("b.ptr4.valid", b_ov, 1);
        b_iv = 5'h00;
        cyc();
        cyc();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
